debug_dump_sequencer: RTL and testbench
=======================================

Name: debug_dump_sequencer

Overview:
- Sequences the UART transmitter on behalf of the pipeline debug path.
- On a dump request it captures a wide snapshot of pipeline state (latch contents, control bits, forwarding selects) in one cycle.
- It then serializes the snapshot into bytes and sends them to uart_tx one at a time, using the tx_start / tx_done handshake.
- It sits between the pipeline debug outputs and uart_tx, and is started by the UART interface control logic after each step or at end of program.

Parameters:
- NB_DATA, 8, UART byte width.
- NB_SNAPSHOT, 144, snapshot width in bits; must be a multiple of NB_DATA (elaboration error otherwise).
- HEADER_BYTE, 8'hA5, frame header value; used only with DUMP_HEADER_EN.
- Derived localparam NB_BYTES = NB_SNAPSHOT/NB_DATA.

Ports:
- clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_dump_req  in  1  start a dump; sampled only in IDLE
- i_snapshot  in  NB_SNAPSHOT  pipeline state to capture
- i_tx_done  in  1  uart_tx byte-complete pulse
- o_tx_start  out  1  one-cycle start pulse to uart_tx
- o_data  out  NB_DATA  byte to transmit; stable from its tx_start through its tx_done
- o_busy  out  1  dump in progress
- o_dump_done  out  1  one-cycle pulse after the last byte's tx_done

Behaviour:
- Reset values (i_rst sampled high at an edge): state=IDLE, o_tx_start=0, o_data=0, o_busy=0, o_dump_done=0, byte index=0, snapshot register=0.
- States: IDLE, SEND, WAIT, DONE. All outputs are registered or decoded from the state register only; no input-to-output combinational path.
- IDLE:
  - On i_dump_req=1: register i_snapshot, index=0, load o_data with byte 0, go to SEND.
  - Otherwise stay in IDLE. i_tx_done is ignored.
- SEND:
  - Lasts exactly 1 cycle; o_tx_start=1 during it. Go to WAIT.
  - i_tx_done seen during SEND is ignored.
- WAIT:
  - Hold o_data. On i_tx_done=1:
    - If index==NB_BYTES-1, go to DONE.
    - Else index+1, load o_data with the next byte, go to SEND.
- DONE:
  - Lasts 1 cycle; o_dump_done=1. Return to IDLE.
- Byte order: most-significant byte first. Byte k = snapshot[NB_SNAPSHOT-1-8k -: 8].
- o_busy=1 in SEND, WAIT and DONE.
- Latency:
  - Request sampled at edge N gives o_tx_start high in cycle N+1.
  - tx_done sampled at edge M gives the next o_tx_start in cycle M+1.
  - Last tx_done at edge M gives o_dump_done in cycle M+1.
- i_dump_req while busy: ignored, not queued. A request held high through DONE is accepted on the first IDLE cycle.
- The snapshot is frozen at capture; i_snapshot changes during a dump do not affect the bytes sent.
- Reset mid-dump: abort immediately to IDLE; no o_dump_done pulse; remaining bytes are not sent.
- No timeout: WAIT holds indefinitely until i_tx_done.

Optional Feature:
- DUMP_HEADER_EN defined:
  - HEADER_BYTE is sent before snapshot byte 0, so frame length is NB_BYTES+1.
  - The index counts 0..NB_BYTES, with index 0 = header.
  - o_data loads HEADER_BYTE on capture.
- DUMP_HEADER_EN undefined: no header; frame length is NB_BYTES; HEADER_BYTE is unused.

Test Plan:
- NB_SNAPSHOT=32, snapshot=0x11223344, req pulse, tx_done 5 cycles after each tx_start -> bytes 0x11, 0x22, 0x33, 0x44 in order; exactly 4 tx_start pulses; o_dump_done one cycle after the 4th tx_done; o_busy low the cycle after.
- Default 144-bit snapshot of alternating 0xAA/0x55 bytes -> 18 tx_start pulses, each o_data matching in MSB-first order; o_data never changes between a tx_start and its tx_done.
- Second i_dump_req and i_snapshot change to 0xFFFFFFFF during byte 2 -> ignored; the original 0x11223344 bytes are sent; no second dump.
- i_rst=1 asserted while waiting for byte 1's tx_done -> next cycle o_busy=0, o_tx_start=0, o_data=0; no o_dump_done; a new req then starts again from byte 0.
- Spurious i_tx_done in IDLE and during SEND -> no state change and no extra tx_start.
- With DUMP_HEADER_EN, 32-bit snapshot 0x11223344 -> bytes 0xA5, 0x11, 0x22, 0x33, 0x44; 5 tx_start pulses, then o_dump_done.

Source files
------------

// File: rtl/debug_dump_sequencer.sv
// Captures a pipeline snapshot and sends it most-significant byte first to uart_tx over tx_start/tx_done.
// DUMP_HEADER_EN: when defined, each frame starts with HEADER_BYTE.
module debug_dump_sequencer #(
  parameter int                 NB_DATA     = 8,
  parameter int                 NB_SNAPSHOT = 144,
  parameter logic [NB_DATA-1:0] HEADER_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_dump_req,
  input  logic [NB_SNAPSHOT-1:0] i_snapshot,
  input  logic                   i_tx_done,
  output logic                   o_tx_start,
  output logic [NB_DATA-1:0]     o_data,
  output logic                   o_busy,
  output logic                   o_dump_done
);

  localparam int NB_BYTES = NB_SNAPSHOT / NB_DATA;
`ifdef DUMP_HEADER_EN
  localparam int NB_FRAME = NB_BYTES + 1;
`else
  localparam int NB_FRAME = NB_BYTES;
`endif
  localparam int                NB_IDX   = (NB_FRAME > 1) ? $clog2(NB_FRAME) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_FRAME - 1);

  generate
    if ((NB_SNAPSHOT % NB_DATA) != 0 || $bits(HEADER_BYTE) != NB_DATA) begin : g_bad_cfg
      $error("debug_dump_sequencer: NB_SNAPSHOT must be a multiple of NB_DATA");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NB_IDX-1:0]      idx_q, idx_d, idx_nxt;
  logic [NB_SNAPSHOT-1:0] snap_q, snap_d;
  logic [NB_DATA-1:0]     data_q, data_d;
  logic [NB_DATA-1:0]     first_byte, next_byte;

  // Byte k of the snapshot, counted from the most-significant end.
  function automatic logic [NB_DATA-1:0] snap_byte(input logic [NB_SNAPSHOT-1:0] snap,
                                                   input logic [NB_IDX-1:0]      k);
    logic [NB_SNAPSHOT-1:0] shifted;
    shifted = snap << (NB_DATA * int'(k));
    return shifted[NB_SNAPSHOT-1 -: NB_DATA];
  endfunction

  assign idx_nxt = idx_q + NB_IDX'(1);

`ifdef DUMP_HEADER_EN
  // Frame index 0 is the header, so frame index j carries snapshot byte j-1.
  assign first_byte = HEADER_BYTE;
  assign next_byte  = snap_byte(snap_q, idx_q);
`else
  assign first_byte = i_snapshot[NB_SNAPSHOT-1 -: NB_DATA];
  assign next_byte  = snap_byte(snap_q, idx_nxt);
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (i_dump_req) begin
          snap_d  = i_snapshot;
          idx_d   = '0;
          data_d  = first_byte;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_nxt;
            data_d  = next_byte;
            state_d = SEND;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_tx_start  = (state_q == SEND);
    o_busy      = (state_q != IDLE);
    o_dump_done = (state_q == DONE);
    o_data      = data_q;
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Drives a 32-bit and a 144-bit sequencer with directed and random dumps, acting as uart_tx.
module tb_debug_dump_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         req32, req144, tx_done;
  logic [31:0]  snap32;
  logic [143:0] snap144;
  logic         start32, busy32, done32, start144, busy144, done144;
  logic [7:0]   data32, data144;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_s32 = 0, cnt_s144 = 0, cnt_d32 = 0, cnt_d144 = 0;

  bit         sel = 1'b0;
  logic       m_start, m_busy, m_done;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  debug_dump_sequencer #(.NB_DATA(8), .NB_SNAPSHOT(32)) u_dut32 (
    .clk(clk), .i_rst(rst), .i_dump_req(req32), .i_snapshot(snap32), .i_tx_done(tx_done),
    .o_tx_start(start32), .o_data(data32), .o_busy(busy32), .o_dump_done(done32)
  );

  debug_dump_sequencer #(.NB_DATA(8), .NB_SNAPSHOT(144)) u_dut144 (
    .clk(clk), .i_rst(rst), .i_dump_req(req144), .i_snapshot(snap144), .i_tx_done(tx_done),
    .o_tx_start(start144), .o_data(data144), .o_busy(busy144), .o_dump_done(done144)
  );

  assign m_start = sel ? start144 : start32;
  assign m_busy  = sel ? busy144  : busy32;
  assign m_done  = sel ? done144  : done32;
  assign m_data  = sel ? data144  : data32;

  // Registered outputs still hold the previous cycle's value at the rising edge.
  always @(posedge clk) begin
    if (start32)  cnt_s32++;
    if (start144) cnt_s144++;
    if (done32)   cnt_d32++;
    if (done144)  cnt_d144++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit s, input logic v);
    if (s) req144 = v; else req32 = v;
  endtask

  // One complete dump acting as uart_tx; expected frame built from the snapshot arithmetically.
  task automatic run_frame(input bit s, input logic [143:0] snap, input int gap,
                           input int disturb_idx, input bit spur_send);
    int         nb, s0, d0;
    logic [7:0] exp_q[$];
    nb = s ? 18 : 4;
`ifdef DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int k = 0; k < nb; k++) exp_q.push_back(8'(snap >> (8 * (nb - 1 - k))));
    sel = s;
    if (s) snap144 = snap; else snap32 = snap[31:0];
    s0 = s ? cnt_s144 : cnt_s32;
    d0 = s ? cnt_d144 : cnt_d32;
    set_req(s, 1'b1);
    @(negedge clk);
    set_req(s, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("tx_start", 64'(m_start), 64'd1);
      chk("data", 64'(m_data), 64'(exp_q[i]));
      chk("busy", 64'(m_busy), 64'd1);
      tx_done = spur_send && (i == 0);
      for (int d = 0; d < gap; d++) begin
        @(negedge clk);
        tx_done = 1'b0;
        if (i == disturb_idx && d == 0) begin
          set_req(s, 1'b1);
          if (s) snap144 = '1; else snap32 = '1;
        end
        if (i == disturb_idx && d == 1) set_req(s, 1'b0);
        chk("hold_start", 64'(m_start), 64'd0);
        chk("hold_data", 64'(m_data), 64'(exp_q[i]));
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    chk("dump_done", 64'(m_done), 64'd1);
    chk("busy_in_done", 64'(m_busy), 64'd1);
    chk("start_in_done", 64'(m_start), 64'd0);
    @(negedge clk);
    chk("done_clear", 64'(m_done), 64'd0);
    chk("busy_clear", 64'(m_busy), 64'd0);
    chk("start_count", 64'((s ? cnt_s144 : cnt_s32) - s0), 64'(exp_q.size()));
    chk("done_count", 64'((s ? cnt_d144 : cnt_d32) - d0), 64'd1);
  endtask

  initial begin
    int s_after, d_after;
    rst = 1'b1; req32 = 1'b0; req144 = 1'b0; tx_done = 1'b0;
    snap32 = '0; snap144 = '0;
    repeat (2) @(negedge clk);
    chk("rst_start32", 64'(start32), 64'd0);
    chk("rst_data32", 64'(data32), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_start144", 64'(start144), 64'd0);
    chk("rst_data144", 64'(data144), 64'd0);
    chk("rst_busy144", 64'(busy144), 64'd0);
    chk("rst_done144", 64'(done144), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Spurious tx_done while idle.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("idle_txdone_start", 64'(start32), 64'd0);
    chk("idle_txdone_busy", 64'(busy32), 64'd0);
    chk("idle_txdone_busy144", 64'(busy144), 64'd0);

    run_frame(1'b0, 144'h11223344, 5, -1, 1'b0);
    run_frame(1'b1, {9{16'hAA55}}, 3, -1, 1'b0);

    // Late request and snapshot change during byte 2 must not matter.
    run_frame(1'b0, 144'h11223344, 4, 2, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("no_second_start", 64'(start32), 64'd0);
      chk("no_second_busy", 64'(busy32), 64'd0);
    end

    run_frame(1'b0, 144'h11223344, 2, -1, 1'b1);

    // Reset while waiting for byte 1's tx_done.
    sel = 1'b0;
    snap32 = 32'h11223344;
    req32 = 1'b1;
    @(negedge clk);
    req32 = 1'b0;
    chk("rstmid_b0", 64'(data32), 64'h11);
    repeat (3) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("rstmid_b1_start", 64'(start32), 64'd1);
    chk("rstmid_b1_data", 64'(data32), 64'h22);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", 64'(busy32), 64'd0);
    chk("rstmid_start", 64'(start32), 64'd0);
    chk("rstmid_data", 64'(data32), 64'd0);
    chk("rstmid_done", 64'(done32), 64'd0);
    s_after = cnt_s32;
    d_after = cnt_d32;
    repeat (6) @(negedge clk);
    chk("rstmid_no_done", 64'(cnt_d32 - d_after), 64'd0);
    chk("rstmid_no_start", 64'(cnt_s32 - s_after), 64'd0);
    run_frame(1'b0, 144'h11223344, 3, -1, 1'b0);

    // Random snapshots and uart_tx turnaround times.
    repeat (4) run_frame(1'b0, 144'($urandom), $urandom_range(6, 1), -1, 1'b0);
    run_frame(1'b1, {$urandom, $urandom, $urandom, $urandom, 16'($urandom)},
              $urandom_range(4, 1), -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
